// File: rtl/inertial_integrator_cal.sv
// inertial_integrator_cal
// Integrates a raw pitch-rate sample stream into a pitch angle. After reset
// (or on request) the block first averages 2^CAL_LOG2 rate samples to learn
// the gyro's zero-rate offset, then integrates offset-corrected rate, with an
// optional fixed-step nudge toward the accelerometer-derived pitch.
module inertial_integrator_cal #(
  parameter int                  W          = 16,
  parameter int                  ACC_W      = 27,
  parameter int                  OUT_SHIFT  = 11,
  parameter int                  CAL_LOG2   = 4,
  parameter logic signed [W-1:0] AZ_OFFSET  = 16'sh00A0,
  parameter int                  FUSE_K     = 327,
  parameter int                  FUSE_SHIFT = 13,
  parameter int                  FUSE_STEP  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld,
  input  logic signed [W-1:0] ptch_rt,
  input  logic signed [W-1:0] AZ,
  input  logic                cal_req,
  input  logic                fuse_en,
  output logic signed [W-1:0] ptch,
  output logic                ptch_vld,
  output logic                cal_done,
  output logic signed [W-1:0] rt_offset
);

  typedef enum logic {CAL, RUN} state_t;

  localparam int SUM_W  = W + CAL_LOG2;  // room for 2^CAL_LOG2 full-scale samples
  localparam int DW     = W + 1;         // rate/AZ differences never wrap
  localparam int EXT_W  = ACC_W + 2;     // integrator update before clamping
  localparam int PROD_W = W + 33;        // AZ difference times a 32-bit gain

  localparam logic signed [EXT_W-1:0]  INT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0]  INT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] ACC_MAX = {{(PROD_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] ACC_MIN = {{(PROD_W-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t                    state;
  logic signed [SUM_W-1:0]   cal_sum;
  logic signed [SUM_W-1:0]   cal_sum_next;
  logic [CAL_LOG2-1:0]       cal_cnt;
  logic signed [ACC_W-1:0]   ptch_int;
  logic signed [ACC_W-1:0]   int_next;
  logic                      upd_q;     // ptch_int took a sample last edge
  logic signed [DW-1:0]      rate_diff;
  logic signed [DW-1:0]      az_diff;
  logic signed [PROD_W-1:0]  az_scaled;
  logic signed [W-1:0]       ptch_acc;
  logic signed [EXT_W-1:0]   fuse_term;
  logic signed [EXT_W-1:0]   int_sum;

  // Datapath: calibration sum, corrected rate, accelerometer pitch, clamped integrator update.
  // NOTE: every signal gets a value before any branch so no latch is inferred.
  always_comb begin
    cal_sum_next = cal_sum + SUM_W'(ptch_rt);
    rate_diff    = DW'(ptch_rt) - DW'(rt_offset);
    az_diff      = DW'(AZ) - DW'(AZ_OFFSET);
    az_scaled    = (PROD_W'(az_diff) * PROD_W'(FUSE_K)) >>> FUSE_SHIFT;

    ptch_acc = az_scaled[W-1:0];
    if (az_scaled > ACC_MAX) ptch_acc = ACC_MAX[W-1:0];
    else if (az_scaled < ACC_MIN) ptch_acc = ACC_MIN[W-1:0];

    // Fixed-size step toward the accelerometer pitch; ties step downward.
    fuse_term = '0;
    if (fuse_en) fuse_term = (ptch_acc > ptch) ? EXT_W'(FUSE_STEP) : -EXT_W'(FUSE_STEP);

    int_sum  = EXT_W'(ptch_int) - EXT_W'(rate_diff) + fuse_term;
    int_next = int_sum[ACC_W-1:0];
    if (int_sum > INT_MAX) int_next = INT_MAX[ACC_W-1:0];
    else if (int_sum < INT_MIN) int_next = INT_MIN[ACC_W-1:0];
  end

  // Control FSM, calibration accumulator, integrator and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CAL;
      cal_sum   <= '0;
      cal_cnt   <= '0;
      ptch_int  <= '0;
      rt_offset <= '0;
      ptch      <= '0;
      ptch_vld  <= 1'b0;
      cal_done  <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      // Output stage trails ptch_int by one edge; forced to zero while calibrating.
      ptch     <= (cal_req || state == CAL) ? '0 : ptch_int[OUT_SHIFT+W-1:OUT_SHIFT];
      ptch_vld <= upd_q && !cal_req && state == RUN;
      upd_q    <= 1'b0;

      if (cal_req) begin
        // Restart calibration; the old offset stays in use until a new one is learned.
        state    <= CAL;
        cal_sum  <= '0;
        cal_cnt  <= '0;
        ptch_int <= '0;
        cal_done <= 1'b0;
      end else if (state == CAL) begin
        if (vld) begin
          if (cal_cnt == '1) begin
            rt_offset <= W'(cal_sum_next >>> CAL_LOG2);
            cal_sum   <= '0;
            cal_cnt   <= '0;
            cal_done  <= 1'b1;
            state     <= RUN;
          end else begin
            cal_sum <= cal_sum_next;
            cal_cnt <= cal_cnt + 1'b1;
          end
        end
      end else if (vld) begin
        ptch_int <= int_next;
        upd_q    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Testbench for inertial_integrator_cal: directed scenarios plus randomized
// traffic, all compared against a plain-arithmetic reference model.
module tb_inertial_integrator_cal;

  logic               clk = 1'b0;
  logic               rst;
  logic               vld;
  logic signed [15:0] ptch_rt;
  logic signed [15:0] AZ;
  logic               cal_req;
  logic               fuse_en;
  logic signed [15:0] ptch;
  logic               ptch_vld;
  logic               cal_done;
  logic signed [15:0] rt_offset;

  int checks = 0;
  int errors = 0;

  // Reference model state, all in plain integers.
  bit     m_run;
  int     m_cnt;
  longint m_sum;
  longint m_off;
  longint m_int;
  longint m_ptch;
  bit     m_pend;
  bit     m_pvld;
  bit     m_done;

  always #5 clk = ~clk;

  inertial_integrator_cal dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .ptch_rt  (ptch_rt),
    .AZ       (AZ),
    .cal_req  (cal_req),
    .fuse_en  (fuse_en),
    .ptch     (ptch),
    .ptch_vld (ptch_vld),
    .cal_done (cal_done),
    .rt_offset(rt_offset)
  );

  task model_reset();
    m_run = 0; m_cnt = 0; m_sum = 0; m_off = 0; m_int = 0;
    m_ptch = 0; m_pend = 0; m_pvld = 0; m_done = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task model_step(input bit v, input int rt, input int az, input bit cr, input bit fe);
    longint acc, nxt, f, p_next;
    bit     pv_next;
    p_next  = (cr || !m_run) ? 0 : (m_int >>> 11);
    pv_next = m_pend && !cr && m_run;
    m_pend  = 0;
    if (cr) begin
      m_run = 0; m_cnt = 0; m_sum = 0; m_int = 0; m_done = 0;
    end else if (!m_run) begin
      if (v) begin
        m_sum += rt;
        m_cnt++;
        if (m_cnt == 16) begin
          m_off = m_sum >>> 4;
          m_sum = 0; m_cnt = 0; m_done = 1; m_run = 1;
        end
      end
    end else if (v) begin
      acc = ((longint'(az) - 160) * 327) >>> 13;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      f = fe ? ((acc > m_ptch) ? 1024 : -1024) : 0;
      nxt = m_int - (longint'(rt) - m_off) + f;
      if (nxt > (64'sd1 <<< 26) - 1) nxt = (64'sd1 <<< 26) - 1;
      if (nxt < -(64'sd1 <<< 26)) nxt = -(64'sd1 <<< 26);
      m_int  = nxt;
      m_pend = 1;
    end
    m_ptch = p_next;
    m_pvld = pv_next;
  endtask

  // One clock: apply inputs at the falling edge, step the model at the rising
  // edge, return at the next falling edge where outputs are sampled.
  task automatic drive(input bit v, input logic [15:0] rt, input logic [15:0] az,
                       input bit cr, input bit fe);
    vld = v; ptch_rt = rt; AZ = az; cal_req = cr; fuse_en = fe;
    @(posedge clk);
    model_step(v, int'($signed(rt)), int'($signed(az)), cr, fe);
    @(negedge clk);
    vld = 1'b0; cal_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; ptch_rt = '0; AZ = '0; cal_req = 1'b0; fuse_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (ptch !== 16'sh0000) begin errors++; $display("FAIL reset_ptch got %h exp 0000", ptch); end
    checks++; if (ptch_vld !== 1'b0) begin errors++; $display("FAIL reset_ptch_vld got %b exp 0", ptch_vld); end
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL reset_cal_done got %b exp 0", cal_done); end
    checks++; if (rt_offset !== 16'sh0000) begin errors++; $display("FAIL reset_rt_offset got %h exp 0000", rt_offset); end
    rst = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (cal_done !== 1'b0 || ptch !== 16'sh0000) begin
      errors++; $display("FAIL reset_idle got done=%b ptch=%h exp done=0 ptch=0000", cal_done, ptch);
    end
  endtask

  task automatic test_calibration();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'h0050, 16'h0000, 1'b0, 1'b0);
      checks++; if (ptch !== 16'sh0000) begin errors++; $display("FAIL cal_ptch sample %0d got %h exp 0000", i, ptch); end
      checks++; if (cal_done !== (i == 15)) begin
        errors++; $display("FAIL cal_done sample %0d got %b exp %b", i, cal_done, (i == 15));
      end
    end
    checks++; if (rt_offset !== 16'sh0050) begin errors++; $display("FAIL cal_offset got %h exp 0050", rt_offset); end
  endtask

  task automatic test_run_nofuse();
    drive(1'b1, 16'hF850, 16'h0000, 1'b0, 1'b0);
    checks++; if (ptch !== 16'sh0000 || ptch_vld !== 1'b0) begin
      errors++; $display("FAIL run_edge0 got ptch=%h vld=%b exp ptch=0000 vld=0", ptch, ptch_vld);
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (ptch !== 16'sh0001 || ptch_vld !== 1'b1) begin
      errors++; $display("FAIL run_edge1 got ptch=%h vld=%b exp ptch=0001 vld=1", ptch, ptch_vld);
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (ptch !== 16'sh0001 || ptch_vld !== 1'b0) begin
      errors++; $display("FAIL run_edge2 got ptch=%h vld=%b exp ptch=0001 vld=0", ptch, ptch_vld);
    end
  endtask

  task automatic test_fuse();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b1, 16'h0050, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b1);
    drive(1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 16'h00A0, 1'b0, 1'b0);
    checks++; if (ptch !== 16'shFFFF) begin errors++; $display("FAIL fuse_two_steps got %h exp ffff", ptch); end
    // A further -1024 only reaches -2 if the two fused steps left exactly -2048.
    drive(1'b1, 16'h0450, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (ptch !== 16'shFFFE) begin errors++; $display("FAIL fuse_depth got %h exp fffe", ptch); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 2100; i++) begin
      drive(1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0);
      checks++; if (longint'(ptch) !== m_ptch) begin
        errors++; $display("FAIL sat_ramp step %0d got %0d exp %0d", i, ptch, m_ptch);
      end
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (ptch !== 16'sh7FFF) begin errors++; $display("FAIL sat_top got %h exp 7fff", ptch); end
    // Stepping down by exactly one output LSB proves the clamp sits at 2^26-1.
    drive(1'b1, 16'h0850, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (ptch !== 16'sh7FFE) begin errors++; $display("FAIL sat_clamp_value got %h exp 7ffe", ptch); end
  endtask

  task automatic test_cal_req();
    drive(1'b1, 16'h1000, 16'h0000, 1'b1, 1'b0);
    checks++; if (cal_done !== 1'b0 || ptch !== 16'sh0000 || ptch_vld !== 1'b0) begin
      errors++; $display("FAIL calreq_clear got done=%b ptch=%h vld=%b exp 0/0000/0", cal_done, ptch, ptch_vld);
    end
    checks++; if (rt_offset !== 16'sh0050) begin errors++; $display("FAIL calreq_keep_offset got %h exp 0050", rt_offset); end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
      checks++; if (cal_done !== (i == 15) || rt_offset !== ((i == 15) ? 16'sh0100 : 16'sh0050)) begin
        errors++; $display("FAIL recal sample %0d got done=%b off=%h exp done=%b off=%h", i, cal_done, rt_offset,
                           (i == 15), ((i == 15) ? 16'sh0100 : 16'sh0050));
      end
      checks++; if (ptch !== 16'sh0000) begin errors++; $display("FAIL recal_ptch sample %0d got %h exp 0000", i, ptch); end
    end
  endtask

  task automatic test_rst_midcal();
    logic [15:0] r;
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (rt_offset !== 16'sh0000 || cal_done !== 1'b0 || ptch !== 16'sh0000 || ptch_vld !== 1'b0) begin
      errors++; $display("FAIL rst_async got off=%h done=%b ptch=%h vld=%b exp all 0", rt_offset, cal_done, ptch, ptch_vld);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = 16'($urandom_range(0, 16'hFFFF));
      drive(1'b1, r, 16'h0000, 1'b0, 1'b0);
      checks++; if (cal_done !== (i == 15)) begin
        errors++; $display("FAIL rst_recal_done sample %0d got %b exp %b", i, cal_done, (i == 15));
      end
    end
    checks++; if (longint'(rt_offset) !== m_off) begin
      errors++; $display("FAIL rst_recal_offset got %0d exp %0d", rt_offset, m_off);
    end
  endtask

  task automatic test_random();
    logic [15:0] r, a;
    bit v, cr, fe;
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      cr = ($urandom_range(0, 63) == 0);
      fe = $urandom_range(0, 1) == 1;
      r  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFF)) : 16'(16'h0040 + $urandom_range(0, 127) - 64);
      a  = 16'($urandom_range(0, 16'hFFFF));
      drive(v, r, a, cr, fe);
      checks++; if (longint'(ptch) !== m_ptch || ptch_vld !== m_pvld || cal_done !== m_done
                    || longint'(rt_offset) !== m_off) begin
        errors++;
        $display("FAIL random cycle %0d got ptch=%0d vld=%b done=%b off=%0d exp ptch=%0d vld=%b done=%b off=%0d",
                 i, ptch, ptch_vld, cal_done, rt_offset, m_ptch, m_pvld, m_done, m_off);
      end
    end
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_run_nofuse();
    test_fuse();
    test_saturation();
    test_cal_req();
    test_rst_midcal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
